// File: rtl/fp_align_if.sv
// Operand/result bundle for fp_align: operand handshake in, aligned result handshake out.
interface fp_align_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_out;
  logic [26:0] mant_l;
  logic [26:0] mant_s;
  logic        sign_l;
  logic        sign_s;
  logic        swapped;
  logic        special;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, exp_out, mant_l, mant_s, sign_l, sign_s, swapped, special
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, exp_out, mant_l, mant_s, sign_l, sign_s, swapped, special
  );
endinterface

// File: rtl/fp_align.sv
// Single-precision operand aligner: orders operands by magnitude and right-shifts the
// smaller mantissa STEP bits per cycle to the larger exponent, keeping guard/round/sticky.
module fp_align #(
  parameter int unsigned STEP = 1
) (
  input  logic clk,
  input  logic rst_n,
  fp_align_if.slave bus
);

  localparam int unsigned MW = 27;
  localparam int unsigned EW = 8;
  localparam int unsigned CW = 5;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [MW-1:0] mant_l_q, mant_l_d;
  logic [MW-1:0] mant_s_q, mant_s_d;
  logic          sign_l_q, sign_l_d;
  logic          sign_s_q, sign_s_d;
  logic          swapped_q, swapped_d;
  logic          special_q, special_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic          b_big;
  logic [31:0]   op_l, op_s;
  logic [EW-1:0] eff_l, eff_s, diff;
  logic [MW-1:0] raw_l, raw_s;
  logic          spec_in;
  logic [CW-1:0] k;
  logic [MW-1:0] sticky_mask, shifted;

  // Unpack the incoming pair, larger magnitude first (A wins ties).
  always_comb begin
    b_big   = bus.b[30:0] > bus.a[30:0];
    op_l    = b_big ? bus.b : bus.a;
    op_s    = b_big ? bus.a : bus.b;
    eff_l   = (op_l[30:23] == 8'd0) ? 8'd1 : op_l[30:23];
    eff_s   = (op_s[30:23] == 8'd0) ? 8'd1 : op_s[30:23];
    raw_l   = {|op_l[30:23], op_l[22:0], 3'b000};
    raw_s   = {|op_s[30:23], op_s[22:0], 3'b000};
    diff    = eff_l - eff_s;
    spec_in = (&bus.a[30:23]) | (&bus.b[30:23]);
  end

  // One shift step: bits falling off the bottom collapse into the sticky bit.
  always_comb begin
    k           = (count_q < CW'(STEP)) ? count_q : CW'(STEP);
    sticky_mask = (MW'(1) << k) - MW'(1);
    shifted     = mant_s_q >> k;
    shifted[0]  = shifted[0] | (|(mant_s_q & sticky_mask));
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    exp_d     = exp_q;
    mant_l_d  = mant_l_q;
    mant_s_d  = mant_s_q;
    sign_l_d  = sign_l_q;
    sign_s_d  = sign_s_q;
    swapped_d = swapped_q;
    special_d = special_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          exp_d     = eff_l;
          mant_l_d  = raw_l;
          mant_s_d  = raw_s;
          sign_l_d  = op_l[31];
          sign_s_d  = op_s[31];
          swapped_d = b_big;
          special_d = spec_in;
          count_d   = '0;
          if (spec_in || diff == 8'd0) begin
            state_d = DONE;
          end else if (diff >= 8'd27) begin
            mant_s_d = (|raw_s) ? MW'(1) : '0;
            state_d  = DONE;
          end else begin
            count_d = diff[CW-1:0];
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        mant_s_d = shifted;
        count_d  = count_q - k;
        if (count_d == '0) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      exp_q       <= '0;
      mant_l_q    <= '0;
      mant_s_q    <= '0;
      sign_l_q    <= 1'b0;
      sign_s_q    <= 1'b0;
      swapped_q   <= 1'b0;
      special_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      exp_q       <= exp_d;
      mant_l_q    <= mant_l_d;
      mant_s_q    <= mant_s_d;
      sign_l_q    <= sign_l_d;
      sign_s_q    <= sign_s_d;
      swapped_q   <= swapped_d;
      special_q   <= special_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.exp_out   = exp_q;
  assign bus.mant_l    = mant_l_q;
  assign bus.mant_s    = mant_s_q;
  assign bus.sign_l    = sign_l_q;
  assign bus.sign_s    = sign_s_q;
  assign bus.swapped   = swapped_q;
  assign bus.special   = special_q;

endmodule

// File: tb/tb_fp_align.sv
// Bench for fp_align: STEP=1 and STEP=4 instances run the same operand stream and are
// compared against an arithmetic model of the alignment and its latency.
module tb_fp_align;

  logic clk = 1'b0;
  logic rst_n;
  logic        in_valid_r;
  logic        out_ready_r;
  logic [31:0] a_r, b_r;

  int checks = 0;
  int errors = 0;

  logic [7:0]  e_exp;
  logic [26:0] e_ml, e_ms;
  logic        e_sl, e_ss, e_sw, e_sp;
  int          e_d;

  fp_align_if ifc1 ();
  fp_align_if ifc4 ();

  assign ifc1.in_valid  = in_valid_r;
  assign ifc1.a         = a_r;
  assign ifc1.b         = b_r;
  assign ifc1.out_ready = out_ready_r;
  assign ifc4.in_valid  = in_valid_r;
  assign ifc4.a         = a_r;
  assign ifc4.b         = b_r;
  assign ifc4.out_ready = out_ready_r;

  fp_align #(.STEP(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));
  fp_align #(.STEP(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(ifc4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Alignment from first principles: integer mantissas, divide for the shift, remainder for sticky.
  task automatic model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] l, s;
    longint el, es, ml, ms, dd, pw;
    e_sw = (b[30:0] > a[30:0]);
    l = e_sw ? b : a;
    s = e_sw ? a : b;
    el = (l[30:23] == 0) ? 1 : longint'(l[30:23]);
    es = (s[30:23] == 0) ? 1 : longint'(s[30:23]);
    ml = ((l[30:23] != 0) ? 64'd8388608 : 64'd0) + longint'(l[22:0]);
    ms = ((s[30:23] != 0) ? 64'd8388608 : 64'd0) + longint'(s[22:0]);
    ml = ml * 8;
    ms = ms * 8;
    dd = el - es;
    e_sp = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    e_exp = 8'(el);
    e_ml = 27'(ml);
    e_sl = l[31];
    e_ss = s[31];
    if (e_sp) begin
      e_ms = 27'(ms);
      e_d = 0;
    end else if (dd >= 27) begin
      e_ms = (ms != 0) ? 27'd1 : 27'd0;
      e_d = 0;
    end else begin
      pw = longint'(1) << dd;
      e_ms = 27'((ms / pw) | ((ms % pw != 0) ? 1 : 0));
      e_d = int'(dd);
    end
  endtask

  task automatic chk_outs(input string tag, input int which);
    if (which == 1) begin
      chk({tag, "/exp1"}, 32'(ifc1.exp_out), 32'(e_exp));
      chk({tag, "/ml1"},  32'(ifc1.mant_l),  32'(e_ml));
      chk({tag, "/ms1"},  32'(ifc1.mant_s),  32'(e_ms));
      chk({tag, "/sgn1"}, 32'({ifc1.sign_l, ifc1.sign_s}), 32'({e_sl, e_ss}));
      chk({tag, "/flg1"}, 32'({ifc1.swapped, ifc1.special}), 32'({e_sw, e_sp}));
    end else begin
      chk({tag, "/exp4"}, 32'(ifc4.exp_out), 32'(e_exp));
      chk({tag, "/ml4"},  32'(ifc4.mant_l),  32'(e_ml));
      chk({tag, "/ms4"},  32'(ifc4.mant_s),  32'(e_ms));
      chk({tag, "/sgn4"}, 32'({ifc4.sign_l, ifc4.sign_s}), 32'({e_sl, e_ss}));
      chk({tag, "/flg4"}, 32'({ifc4.swapped, ifc4.special}), 32'({e_sw, e_sp}));
    end
  endtask

  // Full transaction: accept, measure latency per instance, hold 3 cycles, then handshake.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat1, lat4;
    bit fin;
    model(a, b);
    @(negedge clk);
    chk({tag, "/rdy_in"}, 32'({ifc1.in_ready, ifc4.in_ready}), 32'b11);
    a_r = a;
    b_r = b;
    in_valid_r = 1'b1;
    out_ready_r = 1'b0;
    @(negedge clk);
    in_valid_r = 1'b0;
    a_r = $urandom;
    b_r = $urandom;
    chk({tag, "/busy"}, 32'({ifc1.in_ready, ifc4.in_ready}), 32'b00);
    lat1 = -1;
    lat4 = -1;
    fin = 1'b0;
    for (int k = 0; k < 64 && !fin; k++) begin
      if (ifc1.out_valid === 1'b1 && lat1 < 0) begin
        lat1 = k;
        chk_outs({tag, "/first"}, 1);
      end
      if (ifc4.out_valid === 1'b1 && lat4 < 0) begin
        lat4 = k;
        chk_outs({tag, "/first"}, 4);
      end
      if (lat1 >= 0 && lat4 >= 0 && k >= lat1 + 3 && k >= lat4 + 3) fin = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "/lat1"}, 32'(lat1), 32'(e_d));
    chk({tag, "/lat4"}, 32'(lat4), 32'((e_d + 3) / 4));
    chk({tag, "/held_v"}, 32'({ifc1.out_valid, ifc4.out_valid}), 32'b11);
    chk_outs({tag, "/held"}, 1);
    chk_outs({tag, "/held"}, 4);
    out_ready_r = 1'b1;
    @(negedge clk);
    out_ready_r = 1'b0;
    chk({tag, "/hs_v"}, 32'({ifc1.out_valid, ifc4.out_valid}), 32'b00);
    chk({tag, "/hs_r"}, 32'({ifc1.in_ready, ifc4.in_ready}), 32'b11);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "/v"},  32'({ifc1.out_valid, ifc4.out_valid}), 32'b00);
    chk({tag, "/r"},  32'({ifc1.in_ready, ifc4.in_ready}), 32'b11);
    chk({tag, "/e"},  32'({ifc1.exp_out, ifc4.exp_out}), 32'd0);
    chk({tag, "/l1"}, 32'(ifc1.mant_l), 32'd0);
    chk({tag, "/s1"}, 32'(ifc1.mant_s), 32'd0);
    chk({tag, "/l4"}, 32'(ifc4.mant_l), 32'd0);
    chk({tag, "/s4"}, 32'(ifc4.mant_s), 32'd0);
    chk({tag, "/f"},  32'({ifc1.sign_l, ifc1.sign_s, ifc1.swapped, ifc1.special,
                          ifc4.sign_l, ifc4.sign_s, ifc4.swapped, ifc4.special}), 32'd0);
  endtask

  initial begin
    int ea, eb;
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    in_valid_r = 1'b0;
    out_ready_r = 1'b0;
    a_r = '0;
    b_r = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    rst_n = 1'b1;

    run_op(32'h40400000, 32'h3F800000, "r032");
    run_op(32'h3F800000, 32'h40400000, "r033");
    run_op(32'h41800000, 32'h3F800001, "r034");
    run_op(32'h4B800000, 32'h3D800001, "r035_far");
    run_op(32'h7F800000, 32'h3F800001, "r035_inf");
    run_op(32'h3F800000, 32'h7FC00001, "nan_b");
    run_op(32'h00000003, 32'h00800001, "denorm");
    run_op(32'hC0000000, 32'h40000000, "tie");

    // Reset two cycles into a d=10 shift.
    @(negedge clk);
    a_r = 32'h44800000;
    b_r = 32'h3F800000;
    in_valid_r = 1'b1;
    @(negedge clk);
    in_valid_r = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_cleared("midrst");
    run_op(32'h44800000, 32'h3F800000, "post_rst");

    for (int i = 0; i < 40; i++) begin
      ea = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 254));
      if ($urandom_range(0, 9) == 0) eb = int'($urandom_range(0, 255));
      else begin
        eb = ea + int'($urandom_range(0, 60)) - 30;
        if (eb < 0) eb = 0;
        if (eb > 254) eb = 254;
      end
      ra = {1'($urandom), 8'(ea), 23'($urandom)};
      rb = {1'($urandom), 8'(eb), 23'($urandom)};
      run_op(ra, rb, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
